vram_burst_control: RTL and testbench

- Byte-stream-commanded VRAM bus master; next generation of the single-cycle VRAM poke/peek controller.
- Adds parametrised address width and lane count, multi-word read/write bursts with programmable address stride, and a ready/valid response port.
- Sits between the UART RX/TX pair and the level-shifted VRAM pins in bring-up top levels.

---
 rtl/vram_burst_control.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_vram_burst_control.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_burst_control.sv
// Byte-commanded VRAM bus master with strided multi-word read/write bursts and a ready/valid response port.
// Optional: define VRAM_BURST_CHECKSUM_EN to append an XOR checksum byte to every burst.
module vram_burst_control #(
    parameter int ADDR_BITS           = 15,
    parameter int LANES               = 2,
    parameter int CYCLE_DURATION_BITS = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               cmd_data_i,
    input  logic                     cmd_valid_i,
    output logic [7:0]               resp_data_o,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic                     vrd_n_o,
    output logic [LANES-1:0]         vwr_n_o,
    output logic [ADDR_BITS-1:0]     va_o,
    output logic                     vd_dir_o,
    input  logic [8*LANES-1:0]       vd_i,
    output logic [8*LANES-1:0]       vd_o,
    output logic                     busy_o,
    output logic                     error_bad_opcode_o,
    output logic                     error_overrun_o
);

    localparam logic       LVL_DIR_INPUT  = 1'b0;
    localparam logic       LVL_DIR_OUTPUT = 1'b1;
    localparam int         DW             = 8 * LANES;
    localparam logic [1:0] LAST_LANE      = 2'(LANES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_ARG, EXECUTE, COLLECT, CYCLE, OUTPUT} state_t;
    typedef enum logic [1:0] {MODE_SINGLE, MODE_READ, MODE_WRITE} mode_t;

    function automatic logic [7:0] xor_lanes(input logic [DW-1:0] word);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < LANES; k++) begin
            acc = acc ^ word[8*k +: 8];
        end
        return acc;
    endfunction

    state_t                         state_r, state_s;
    mode_t                          mode_r, mode_s;
    logic [7:0]                     opcode_r, opcode_s;
    logic [7:0]                     arg_r, arg_s;
    logic [ADDR_BITS-1:0]           addr_r, addr_s;
    logic [7:0]                     stride_r, stride_s;
    logic [CYCLE_DURATION_BITS-1:0] duration_r, duration_s;
    logic [CYCLE_DURATION_BITS-1:0] cnt_r, cnt_s;
    logic [7:0]                     words_r, words_s;
    logic [1:0]                     lane_r, lane_s;
    logic [DW-1:0]                  data_r, data_s;
    logic [7:0]                     csum_r, csum_s;
    logic [7:0]                     resp_data_r, resp_data_s;
    logic                           resp_valid_r, resp_valid_s;
    logic                           vrd_n_r, vrd_n_s;
    logic [LANES-1:0]               vwr_n_r, vwr_n_s;
    logic [ADDR_BITS-1:0]           va_r, va_s;
    logic                           vd_dir_r, vd_dir_s;
    logic [DW-1:0]                  vd_r, vd_s;
    logic                           busy_r, busy_s;
    logic                           err_bad_r, err_bad_s;
    logic                           err_ovr_r, err_ovr_s;
    logic [ADDR_BITS-1:0]           addr_inc_s;

    assign addr_inc_s = addr_r + ADDR_BITS'(stride_r);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_s      = state_r;
        mode_s       = mode_r;
        opcode_s     = opcode_r;
        arg_s        = arg_r;
        addr_s       = addr_r;
        stride_s     = stride_r;
        duration_s   = duration_r;
        cnt_s        = cnt_r;
        words_s      = words_r;
        lane_s       = lane_r;
        data_s       = data_r;
        csum_s       = csum_r;
        resp_data_s  = resp_data_r;
        resp_valid_s = resp_valid_r;
        err_bad_s    = err_bad_r;
        err_ovr_s    = err_ovr_r;
        vrd_n_s      = 1'b1;
        vwr_n_s      = '1;
        va_s         = '0;
        vd_dir_s     = LVL_DIR_INPUT;
        vd_s         = '0;

        case (state_r)
            IDLE: begin
                if (cmd_valid_i) begin
                    opcode_s = cmd_data_i;
                    state_s  = WAIT_ARG;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT_ARG: begin
                if (cmd_valid_i) begin
                    arg_s   = cmd_data_i;
                    state_s = EXECUTE;
                end else begin
                    state_s = WAIT_ARG;
                end
            end
            EXECUTE: begin
                state_s = IDLE;
                case (opcode_r)
                    8'h00: state_s = IDLE;
                    8'h01: begin
                        resp_data_s  = arg_r;
                        resp_valid_s = 1'b1;
                        mode_s       = MODE_SINGLE;
                        state_s      = OUTPUT;
                    end
                    8'h10: begin
                        addr_s     = '0;
                        stride_s   = 8'h01;
                        duration_s = '1;
                        err_bad_s  = 1'b0;
                        err_ovr_s  = 1'b0;
                    end
                    8'h20: addr_s[7:0] = arg_r;
                    8'h21: addr_s[ADDR_BITS-1:8] = arg_r[ADDR_BITS-9:0];
                    8'h22: stride_s = arg_r;
                    8'h60: duration_s = CYCLE_DURATION_BITS'(arg_r);
                    8'h80: begin
                        words_s = arg_r;
                        lane_s  = 2'd0;
                        csum_s  = 8'h00;
                        mode_s  = MODE_WRITE;
                        state_s = COLLECT;
                    end
                    8'h90: begin
                        words_s = arg_r;
                        csum_s  = 8'h00;
                        mode_s  = MODE_READ;
                        cnt_s   = duration_r;
                        vrd_n_s = 1'b0;
                        va_s    = addr_r;
                        state_s = CYCLE;
                    end
                    default: err_bad_s = 1'b1;
                endcase
            end
            COLLECT: begin
                if (cmd_valid_i) begin
                    data_s[{lane_r, 3'b000} +: 8] = cmd_data_i;
                    csum_s = csum_r ^ cmd_data_i;
                    if (lane_r == LAST_LANE) begin
                        cnt_s    = duration_r;
                        vwr_n_s  = '0;
                        va_s     = addr_r;
                        vd_s     = data_s;
                        vd_dir_s = LVL_DIR_OUTPUT;
                        state_s  = CYCLE;
                    end else begin
                        lane_s   = lane_r + 2'd1;
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            CYCLE: begin
                if (cmd_valid_i) begin
                    err_ovr_s = 1'b1;
                end else begin
                    err_ovr_s = err_ovr_r;
                end
                if (cnt_r != '0) begin
                    cnt_s    = cnt_r - CYCLE_DURATION_BITS'(1);
                    vrd_n_s  = vrd_n_r;
                    vwr_n_s  = vwr_n_r;
                    va_s     = va_r;
                    vd_s     = vd_r;
                    vd_dir_s = vd_dir_r;
                end else begin
                    addr_s = addr_inc_s;
                    lane_s = 2'd0;
                    if (mode_r == MODE_READ) begin
                        // Last strobe-low clock: capture the word and start presenting lane 0.
                        data_s       = vd_i;
                        csum_s       = csum_r ^ xor_lanes(vd_i);
                        resp_data_s  = vd_i[7:0];
                        resp_valid_s = 1'b1;
                        state_s      = OUTPUT;
                    end else if (words_r == 8'd0) begin
`ifdef VRAM_BURST_CHECKSUM_EN
                        resp_data_s  = csum_r;
                        resp_valid_s = 1'b1;
                        mode_s       = MODE_SINGLE;
                        state_s      = OUTPUT;
`else
                        state_s      = IDLE;
`endif
                    end else begin
                        words_s = words_r - 8'd1;
                        state_s = COLLECT;
                    end
                end
            end
            OUTPUT: begin
                if (cmd_valid_i) begin
                    err_ovr_s = 1'b1;
                end else begin
                    err_ovr_s = err_ovr_r;
                end
                if (resp_ready_i) begin
                    resp_valid_s = 1'b0;
                    if (mode_r == MODE_SINGLE) begin
                        state_s = IDLE;
                    end else if (lane_r != LAST_LANE) begin
                        lane_s       = lane_r + 2'd1;
                        resp_data_s  = data_r[{lane_r + 2'd1, 3'b000} +: 8];
                        resp_valid_s = 1'b1;
                    end else if (words_r == 8'd0) begin
`ifdef VRAM_BURST_CHECKSUM_EN
                        resp_data_s  = csum_r;
                        resp_valid_s = 1'b1;
                        mode_s       = MODE_SINGLE;
`else
                        state_s      = IDLE;
`endif
                    end else begin
                        words_s = words_r - 8'd1;
                        cnt_s   = duration_r;
                        vrd_n_s = 1'b0;
                        va_s    = addr_r;
                        state_s = CYCLE;
                    end
                end else begin
                    state_s = OUTPUT;
                end
            end
            default: state_s = IDLE;
        endcase

        busy_s = (state_s != IDLE);
    end

    // Datapath, configuration and registered bus/response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_r       <= MODE_SINGLE;
            opcode_r     <= 8'h00;
            arg_r        <= 8'h00;
            addr_r       <= '0;
            stride_r     <= 8'h01;
            duration_r   <= '1;
            cnt_r        <= '0;
            words_r      <= 8'h00;
            lane_r       <= 2'd0;
            data_r       <= '0;
            csum_r       <= 8'h00;
            resp_data_r  <= 8'h00;
            resp_valid_r <= 1'b0;
            vrd_n_r      <= 1'b1;
            vwr_n_r      <= '1;
            va_r         <= '0;
            vd_dir_r     <= LVL_DIR_INPUT;
            vd_r         <= '0;
            busy_r       <= 1'b0;
            err_bad_r    <= 1'b0;
            err_ovr_r    <= 1'b0;
        end else begin
            mode_r       <= mode_s;
            opcode_r     <= opcode_s;
            arg_r        <= arg_s;
            addr_r       <= addr_s;
            stride_r     <= stride_s;
            duration_r   <= duration_s;
            cnt_r        <= cnt_s;
            words_r      <= words_s;
            lane_r       <= lane_s;
            data_r       <= data_s;
            csum_r       <= csum_s;
            resp_data_r  <= resp_data_s;
            resp_valid_r <= resp_valid_s;
            vrd_n_r      <= vrd_n_s;
            vwr_n_r      <= vwr_n_s;
            va_r         <= va_s;
            vd_dir_r     <= vd_dir_s;
            vd_r         <= vd_s;
            busy_r       <= busy_s;
            err_bad_r    <= err_bad_s;
            err_ovr_r    <= err_ovr_s;
        end
    end

    assign resp_data_o        = resp_data_r;
    assign resp_valid_o       = resp_valid_r;
    assign vrd_n_o            = vrd_n_r;
    assign vwr_n_o            = vwr_n_r;
    assign va_o               = va_r;
    assign vd_dir_o           = vd_dir_r;
    assign vd_o               = vd_r;
    assign busy_o             = busy_r;
    assign error_bad_opcode_o = err_bad_r;
    assign error_overrun_o    = err_ovr_r;

endmodule

// File: tb/tb_vram_burst_control.sv
// Directed self-checking bench for vram_burst_control (ADDR_BITS=15, LANES=2).
module tb_vram_burst_control;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cmd_data_i = 8'h00;
    logic        cmd_valid_i = 1'b0;
    logic [7:0]  resp_data_o;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic        vrd_n_o;
    logic [1:0]  vwr_n_o;
    logic [14:0] va_o;
    logic        vd_dir_o;
    logic [15:0] vd_i;
    logic [15:0] vd_o;
    logic        busy_o;
    logic        error_bad_opcode_o;
    logic        error_overrun_o;

    int n_vectors = 0;
    int n_miscompares = 0;
    int bus_viol = 0;

    logic [7:0]  resp_q[$];
    logic [14:0] cyc_addr[$];
    logic [15:0] cyc_data[$];
    int          cyc_len[$];
    bit          cyc_wr[$];

    vram_burst_control #(.ADDR_BITS(15), .LANES(2), .CYCLE_DURATION_BITS(6)) dut (
        .clock(clock), .reset(reset),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i),
        .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .vrd_n_o(vrd_n_o), .vwr_n_o(vwr_n_o), .va_o(va_o), .vd_dir_o(vd_dir_o),
        .vd_i(vd_i), .vd_o(vd_o), .busy_o(busy_o),
        .error_bad_opcode_o(error_bad_opcode_o), .error_overrun_o(error_overrun_o)
    );

    initial forever #5 clock = ~clock;

    // VRAM read model: address-derived data, only while the read strobe is low.
    assign vd_i = vrd_n_o ? 16'hEEEE : {({1'b0, va_o[14:8]} ^ 8'hC3), (va_o[7:0] ^ 8'h5A)};

    // Bus/response monitor sampling on the falling edge.
    initial begin
        int          run_len;
        logic [14:0] run_addr;
        logic [15:0] run_data;
        bit          run_wr;
        bit          prev_stall;
        logic [7:0]  prev_data;
        run_len = 0; run_addr = '0; run_data = '0; run_wr = 1'b0;
        prev_stall = 1'b0; prev_data = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                run_len = 0;
                prev_stall = 1'b0;
            end else begin
                if (!vrd_n_o || vwr_n_o != 2'b11) begin
                    if (!vrd_n_o && vwr_n_o != 2'b11) bus_viol++;
                    if (vwr_n_o != 2'b11 && vwr_n_o != 2'b00) bus_viol++;
                    if (run_len == 0) begin
                        run_addr = va_o; run_data = vd_o; run_wr = (vwr_n_o != 2'b11);
                    end else if (va_o !== run_addr || vd_o !== run_data) begin
                        bus_viol++;
                    end
                    if (vd_dir_o !== (run_wr ? DIR_OUT : DIR_IN)) bus_viol++;
                    run_len++;
                end else begin
                    if (run_len != 0) begin
                        cyc_addr.push_back(run_addr); cyc_data.push_back(run_data);
                        cyc_len.push_back(run_len); cyc_wr.push_back(run_wr);
                        run_len = 0;
                    end
                    if (va_o !== 15'h0000 || vd_o !== 16'h0000 || vd_dir_o !== DIR_IN) bus_viol++;
                end
                if (prev_stall && (resp_valid_o !== 1'b1 || resp_data_o !== prev_data)) bus_viol++;
                prev_stall = resp_valid_o && !resp_ready_i;
                prev_data = resp_data_o;
                if (resp_valid_o && resp_ready_i) resp_q.push_back(resp_data_o);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        cmd_data_i = b; cmd_valid_i = 1'b1;
        @(posedge clock); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg);
        send_byte(op);
        send_byte(arg);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(posedge clock); #1;
            k++;
        end while (busy_o && k < budget);
        if (busy_o) begin
            n_vectors++; n_miscompares++;
            $display("FAIL wait_idle: busy_o still %b after %0d clocks, required 0", busy_o, budget);
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        resp_q.delete(); cyc_addr.delete(); cyc_data.delete(); cyc_len.delete(); cyc_wr.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_vectors++;
        if ({vrd_n_o, vwr_n_o, vd_dir_o, resp_valid_o, busy_o, error_bad_opcode_o, error_overrun_o} !== 8'b1110_0000
            || va_o !== 15'h0000 || vd_o !== 16'h0000) begin
            n_miscompares++;
            $display("FAIL reset_values: ctl=%b va=%h vd=%h, required ctl=11100000 va=0000 vd=0000",
                     {vrd_n_o, vwr_n_o, vd_dir_o, resp_valid_o, busy_o, error_bad_opcode_o, error_overrun_o}, va_o, vd_o);
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_vectors++;
        if (busy_o !== 1'b0 || vrd_n_o !== 1'b1 || vwr_n_o !== 2'b11) begin
            n_miscompares++;
            $display("FAIL after_release: busy=%b vrd_n=%b vwr_n=%b, required 0 1 11", busy_o, vrd_n_o, vwr_n_o);
        end
    endtask

    task automatic test_echo();
        int v0;
        clear_logs(); v0 = bus_viol;
        send_cmd(8'h01, 8'h5A);
        wait_idle(50);
        n_vectors++;
        if (resp_q.size() != 1 || resp_q[0] !== 8'h5A) begin
            n_miscompares++;
            $display("FAIL echo_resp: got %0d bytes first=%h, required 1 byte 5a", resp_q.size(), resp_q.size() > 0 ? resp_q[0] : 8'hxx);
        end
        n_vectors++;
        if (cyc_addr.size() != 0 || bus_viol != v0 || busy_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL echo_bus_idle: cycles=%0d viol=%0d busy=%b, required 0 0 0", cyc_addr.size(), bus_viol - v0, busy_o);
        end
    endtask

    task automatic test_write_burst();
        int v0;
        logic [7:0] wbytes[4] = '{8'hAA, 8'h55, 8'h11, 8'h22};
        logic [14:0] exp_a[2] = '{15'h0123, 15'h0124};
        logic [15:0] exp_d[2] = '{16'h55AA, 16'h2211};
        clear_logs(); v0 = bus_viol;
        send_cmd(8'h20, 8'h23);
        send_cmd(8'h21, 8'h01);
        send_cmd(8'h60, 8'h03);
        send_cmd(8'h80, 8'h01);
        for (int i = 0; i < 4; i++) begin
            send_byte(wbytes[i]);
            if (i % 2 == 1) repeat (8) @(posedge clock);
        end
        wait_idle(100);
        n_vectors++;
        if (cyc_addr.size() != 2) begin
            n_miscompares++;
            $display("FAIL write_count: got %0d cycles, required 2", cyc_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vectors++;
                if (cyc_addr[i] !== exp_a[i] || cyc_data[i] !== exp_d[i] || cyc_len[i] != 4 || !cyc_wr[i]) begin
                    n_miscompares++;
                    $display("FAIL write_cycle%0d: addr=%h data=%h len=%0d wr=%b, required %h %h 4 1",
                             i, cyc_addr[i], cyc_data[i], cyc_len[i], cyc_wr[i], exp_a[i], exp_d[i]);
                end
            end
        end
        n_vectors++;
`ifdef VRAM_BURST_CHECKSUM_EN
        if (resp_q.size() != 1 || resp_q[0] !== 8'hCC) begin
            n_miscompares++;
            $display("FAIL write_checksum: got %0d bytes, required 1 byte cc", resp_q.size());
        end
`else
        if (resp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL write_no_resp: got %0d bytes, required 0", resp_q.size());
        end
`endif
        n_vectors++;
        if (bus_viol != v0 || error_overrun_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL write_bus_rules: viol=%0d overrun=%b, required 0 0", bus_viol - v0, error_overrun_o);
        end
    endtask

    task automatic test_read_stall();
        int v0;
        int k;
        logic [7:0]  exp_b[6] = '{8'h7F, 8'hC2, 8'h7D, 8'hC2, 8'h73, 8'hC2};
        logic [14:0] exp_a[3] = '{15'h0125, 15'h0127, 15'h0129};
        clear_logs(); v0 = bus_viol;
        send_cmd(8'h22, 8'h02);
        send_cmd(8'h90, 8'h02);
        k = 0;
        while (resp_q.size() < 3 && k < 500) begin
            @(posedge clock); #1;
            k++;
        end
        resp_ready_i = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        n_vectors++;
        if (resp_q.size() != 3 || resp_valid_o !== 1'b1) begin
            n_miscompares++;
            $display("FAIL read_stall: bytes=%0d valid=%b, required 3 1", resp_q.size(), resp_valid_o);
        end
        resp_ready_i = 1'b1;
        wait_idle(500);
        n_vectors++;
`ifdef VRAM_BURST_CHECKSUM_EN
        if (resp_q.size() != 7 || resp_q[6] !== 8'hB3) begin
`else
        if (resp_q.size() != 6) begin
`endif
            n_miscompares++;
            $display("FAIL read_count: got %0d bytes, required 6 data bytes (plus checksum b3 if enabled)", resp_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_vectors++;
            if (resp_q.size() <= i || resp_q[i] !== exp_b[i]) begin
                n_miscompares++;
                $display("FAIL read_byte%0d: got %h, required %h", i, resp_q.size() > i ? resp_q[i] : 8'hxx, exp_b[i]);
            end
        end
        n_vectors++;
        if (cyc_addr.size() != 3 || cyc_addr[0] !== exp_a[0] || cyc_addr[1] !== exp_a[1] || cyc_addr[2] !== exp_a[2]
            || cyc_len[0] != 4 || cyc_wr[0] || bus_viol != v0) begin
            n_miscompares++;
            $display("FAIL read_cycles: n=%0d viol=%0d, required 3 cycles at 0125/0127/0129 len 4 read, 0 viol",
                     cyc_addr.size(), bus_viol - v0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_b[4] = '{8'hA5, 8'hBC, 8'h5A, 8'hC3};
        clear_logs();
        send_cmd(8'h20, 8'hFF);
        send_cmd(8'h21, 8'h7F);
        send_cmd(8'h22, 8'h01);
        send_cmd(8'h90, 8'h01);
        wait_idle(300);
        n_vectors++;
        if (cyc_addr.size() != 2 || cyc_addr[0] !== 15'h7FFF || cyc_addr[1] !== 15'h0000) begin
            n_miscompares++;
            $display("FAIL wrap_addr: n=%0d a0=%h a1=%h, required 2 cycles 7fff 0000", cyc_addr.size(),
                     cyc_addr.size() > 0 ? cyc_addr[0] : 15'hx, cyc_addr.size() > 1 ? cyc_addr[1] : 15'hx);
        end
        for (int i = 0; i < 4; i++) begin
            n_vectors++;
            if (resp_q.size() <= i || resp_q[i] !== exp_b[i]) begin
                n_miscompares++;
                $display("FAIL wrap_byte%0d: got %h, required %h", i, resp_q.size() > i ? resp_q[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_errors();
        send_cmd(8'h77, 8'h00);
        wait_idle(50);
        n_vectors++;
        if (error_bad_opcode_o !== 1'b1 || error_overrun_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL bad_opcode: bad=%b ovr=%b, required 1 0", error_bad_opcode_o, error_overrun_o);
        end
        send_cmd(8'h90, 8'h00);
        send_byte(8'hEE);
        wait_idle(200);
        n_vectors++;
        if (error_overrun_o !== 1'b1 || error_bad_opcode_o !== 1'b1) begin
            n_miscompares++;
            $display("FAIL overrun: ovr=%b bad=%b, required 1 1", error_overrun_o, error_bad_opcode_o);
        end
        send_cmd(8'h10, 8'h00);
        wait_idle(50);
        n_vectors++;
        if (error_overrun_o !== 1'b0 || error_bad_opcode_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL reset_opcode: ovr=%b bad=%b, required 0 0", error_overrun_o, error_bad_opcode_o);
        end
        clear_logs();
        send_cmd(8'h90, 8'h00);
        wait_idle(300);
        n_vectors++;
        if (cyc_addr.size() != 1 || cyc_addr[0] !== 15'h0000 || cyc_len[0] != 64 || resp_q.size() < 2 || resp_q[0] !== 8'h5A) begin
            n_miscompares++;
            $display("FAIL regs_defaults: n=%0d addr=%h len=%0d, required 1 cycle at 0000 len 64 first byte 5a",
                     cyc_addr.size(), cyc_addr.size() > 0 ? cyc_addr[0] : 15'hx, cyc_len.size() > 0 ? cyc_len[0] : -1);
        end
    endtask

    task automatic test_async_reset();
        int k;
        clear_logs();
        send_cmd(8'h80, 8'h01);
        send_byte(8'hAA);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        n_vectors++;
        if (busy_o !== 1'b0 || vwr_n_o !== 2'b11 || resp_valid_o !== 1'b0 || va_o !== 15'h0000) begin
            n_miscompares++;
            $display("FAIL reset_in_collect: busy=%b vwr_n=%b valid=%b va=%h, required 0 11 0 0000", busy_o, vwr_n_o, resp_valid_o, va_o);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        send_cmd(8'h90, 8'h00);
        k = 0;
        while (vrd_n_o && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        n_vectors++;
        if (vrd_n_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL read_start: vrd_n=%b after %0d clocks, required 0", vrd_n_o, k);
        end
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_vectors++;
        if (vrd_n_o !== 1'b1 || va_o !== 15'h0000 || busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL reset_in_cycle: vrd_n=%b va=%h busy=%b valid=%b, required 1 0000 0 0", vrd_n_o, va_o, busy_o, resp_valid_o);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        cyc_addr.delete(); cyc_data.delete(); cyc_len.delete(); cyc_wr.delete();
        repeat (80) @(posedge clock);
        #1;
        n_vectors++;
        if (cyc_addr.size() != 0 || resp_q.size() != 0 || busy_o !== 1'b0) begin
            n_miscompares++;
            $display("FAIL after_abort: cycles=%0d resp=%0d busy=%b, required 0 0 0", cyc_addr.size(), resp_q.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_write_burst();
        test_read_stall();
        test_wrap();
        test_errors();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
